// File: rtl/tone_generator.sv
`default_nettype none
// ============================================================================
// Module      : tone_generator
// Description : Square-wave audio stage fed by the switch-to-note decoder.
//               freq_in is a half-period length in clock cycles (0 = silence).
//               The wave is glitch-free: frequency changes and note-off are
//               only acted on at half-period boundaries, so a half period is
//               never truncated and the wave always ends low.
//               Optional feature macro: TONE_SUSTAIN_EN (adds a SUSTAIN state
//               that keeps the tone going for SUSTAIN_CYCLES after release).
// Ports       : clk         - system clock
//               reset       - synchronous, active-high reset
//               freq_in     - half-period count (HALF_W bits), 0 = silence
//               audio_out   - square wave to amplifier input
//               audio_sd    - amplifier enable, 1 while a note sounds
//               note_active - 1 whenever the generator is not silent
// Revision    : 1.0 - initial release
// ============================================================================
module tone_generator #(
    parameter int HALF_W         = 18,
    parameter int MIN_HALF       = 2,
    parameter int SUSTAIN_CYCLES = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HALF_W-1:0] freq_in,
    output logic              audio_out,
    output logic              audio_sd,
    output logic              note_active
);

    localparam logic [HALF_W-1:0] c_MIN_HALF = HALF_W'(MIN_HALF);
    localparam logic [HALF_W-1:0] c_ONE      = HALF_W'(1);

    localparam logic [1:0] c_ST_SILENT  = 2'd0;
    localparam logic [1:0] c_ST_PLAYING = 2'd1;
`ifdef TONE_SUSTAIN_EN
    localparam logic [1:0] c_ST_SUSTAIN = 2'd2;

    // Counter saturates at SUSTAIN_CYCLES, so it only needs to reach that value.
    localparam int              c_SUS_W   = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES + 1) : 1;
    localparam logic [c_SUS_W-1:0] c_SUS_MAX = c_SUS_W'(SUSTAIN_CYCLES);
    localparam logic [c_SUS_W-1:0] c_SUS_ONE = c_SUS_W'(1);

    logic [c_SUS_W-1:0] r_sus_cnt;
    logic [c_SUS_W-1:0] w_sus_cnt_nxt;
`else
    // Release hold time has no meaning without the sustain feature.
    localparam int c_unused_sustain_cycles = SUSTAIN_CYCLES;
`endif

    logic [HALF_W-1:0] r_freq_q;
    logic [HALF_W-1:0] r_active_half;
    logic [HALF_W-1:0] r_cnt;
    logic [1:0]        r_state;
    logic              r_audio;
    logic              r_sd;

    logic [HALF_W-1:0] w_active_half_nxt;
    logic [HALF_W-1:0] w_cnt_nxt;
    logic [1:0]        w_state_nxt;
    logic              w_audio_nxt;
    logic              w_boundary;
    logic              w_freq_nz;

    // active_half is always >= MIN_HALF (>= 2) while sounding, so the
    // subtraction cannot underflow in the states where it matters.
    assign w_boundary = (r_cnt == (r_active_half - c_ONE));
    assign w_freq_nz  = (r_freq_q != '0);

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_audio_nxt       = r_audio;
        w_active_half_nxt = r_active_half;
        w_cnt_nxt         = r_cnt;
`ifdef TONE_SUSTAIN_EN
        w_sus_cnt_nxt     = r_sus_cnt;
`endif

        case (r_state)
            c_ST_SILENT: begin
                w_cnt_nxt   = '0;
                w_audio_nxt = 1'b0;
                if (w_freq_nz) begin
                    w_active_half_nxt = r_freq_q;
                    w_state_nxt       = c_ST_PLAYING;
                end
            end

            c_ST_PLAYING: begin
                if (w_boundary) begin
                    w_cnt_nxt = '0;
                    if (w_freq_nz) begin
                        // New frequency is only ever picked up here.
                        w_audio_nxt       = ~r_audio;
                        w_active_half_nxt = r_freq_q;
                    end else begin
`ifdef TONE_SUSTAIN_EN
                        w_audio_nxt   = ~r_audio;
                        w_state_nxt   = c_ST_SUSTAIN;
                        w_sus_cnt_nxt = '0;
`else
                        // Ending a high half drops low; ending a low half
                        // simply stays low. Either way the wave ends low.
                        w_audio_nxt = 1'b0;
                        w_state_nxt = c_ST_SILENT;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end

`ifdef TONE_SUSTAIN_EN
            c_ST_SUSTAIN: begin
                if (r_sus_cnt != c_SUS_MAX) begin
                    w_sus_cnt_nxt = r_sus_cnt + c_SUS_ONE;
                end
                if (w_boundary) begin
                    w_cnt_nxt = '0;
                    if (w_freq_nz) begin
                        w_audio_nxt       = ~r_audio;
                        w_active_half_nxt = r_freq_q;
                        w_state_nxt       = c_ST_PLAYING;
                    end else if (r_sus_cnt >= c_SUS_MAX) begin
                        w_audio_nxt = 1'b0;
                        w_state_nxt = c_ST_SILENT;
                    end else begin
                        w_audio_nxt = ~r_audio;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
`endif

            default: begin
                w_cnt_nxt   = '0;
                w_audio_nxt = 1'b0;
                w_state_nxt = c_ST_SILENT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_freq_q      <= '0;
            r_active_half <= '0;
            r_cnt         <= '0;
            r_state       <= c_ST_SILENT;
            r_audio       <= 1'b0;
            r_sd          <= 1'b0;
        end else begin
            // Sub-minimum counts would make a degenerate wave; treat as silence.
            r_freq_q      <= (freq_in < c_MIN_HALF) ? '0 : freq_in;
            r_active_half <= w_active_half_nxt;
            r_cnt         <= w_cnt_nxt;
            r_state       <= w_state_nxt;
            r_audio       <= w_audio_nxt;
            // Registered from next state so the enable falls on the same edge
            // that the wave settles low.
            r_sd          <= (w_state_nxt != c_ST_SILENT);
        end
    end

`ifdef TONE_SUSTAIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sus_cnt <= '0;
        end else begin
            r_sus_cnt <= w_sus_cnt_nxt;
        end
    end
`endif

    assign audio_out   = r_audio;
    assign audio_sd    = r_sd;
    assign note_active = r_sd;

endmodule
`default_nettype wire

// File: tb/tb_tone_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_generator
// Description : Self-checking bench for tone_generator. Directed scenarios
//               with fixed expected timing plus randomized note sequences
//               compared against a half-period countdown reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_generator;

    localparam int HALF_W = 18;
    localparam int SUS    = 20;
`ifdef TONE_SUSTAIN_EN
    localparam bit SUSTAIN_ON = 1'b1;
`else
    localparam bit SUSTAIN_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [HALF_W-1:0] freq_in;
    logic              audio_out;
    logic              audio_sd;
    logic              note_active;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: delayed input, whether a note sounds, wave level,
    // cycles left in the current half, length of the current half.
    int m_fq, m_left, m_half, m_sus;
    bit m_playing, m_level, m_sustain;

    always #5 clk = ~clk;

    tone_generator #(
        .HALF_W         (HALF_W),
        .MIN_HALF       (2),
        .SUSTAIN_CYCLES (SUS)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .freq_in     (freq_in),
        .audio_out   (audio_out),
        .audio_sd    (audio_sd),
        .note_active (note_active)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour, from pre-edge inputs.
    task automatic model_step(input bit rst_v, input int f_in);
        int old_sus;
        if (rst_v) begin
            m_fq = 0; m_left = 0; m_half = 0; m_sus = 0;
            m_playing = 0; m_level = 0; m_sustain = 0;
        end else begin
            if (!m_playing) begin
                if (m_fq != 0) begin
                    m_playing = 1; m_sustain = 0;
                    m_half = m_fq; m_left = m_fq;
                end
            end else begin
                old_sus = m_sus;
                if (m_sustain && m_sus < SUS) m_sus++;
                m_left--;
                if (m_left == 0) begin
                    if (m_fq != 0) begin
                        m_level = !m_level; m_half = m_fq; m_left = m_fq; m_sustain = 0;
                    end else if (SUSTAIN_ON && !m_sustain) begin
                        m_level = !m_level; m_left = m_half; m_sustain = 1; m_sus = 0;
                    end else if (m_sustain && old_sus < SUS) begin
                        m_level = !m_level; m_left = m_half;
                    end else begin
                        m_level = 0; m_playing = 0; m_sustain = 0;
                    end
                end
            end
            m_fq = (f_in < 2) ? 0 : f_in;
        end
    endtask

    task automatic tick(input bit rst_v, input int f);
        reset   = rst_v;
        freq_in = f[HALF_W-1:0];
        @(posedge clk);
        model_step(rst_v, f);
        #1;
        chk("audio_out",   audio_out,   m_level);
        chk("audio_sd",    audio_sd,    m_playing);
        chk("note_active", note_active, m_playing);
    endtask

    // From silence: freq_in=4 before edge 1 -> enable after edge 2,
    // rise at 6, fall at 10, rise at 14.
    task automatic run_start4();
        for (int e = 1; e <= 14; e++) begin
            tick(1'b0, 4);
            chk("t1_sd",  audio_sd,  e >= 2);
            chk("t1_out", audio_out, (e >= 6) && (((e - 6) / 4) % 2 == 0));
        end
    endtask

    initial begin
        int f, hold, sel;
        reset   = 1'b1;
        freq_in = '0;

        // Reset state
        tick(1'b1, 0);
        tick(1'b1, 0);
        chk("rst_out", audio_out, 0);
        chk("rst_sd",  audio_sd, 0);
        chk("rst_na",  note_active, 0);

        // Start timing, then reset in the middle of a high half and restart
        run_start4();
        tick(1'b0, 4);
        tick(1'b1, 4);
        chk("t5_out", audio_out, 0);
        chk("t5_sd",  audio_sd, 0);
        chk("t5_na",  note_active, 0);
        run_start4();

        // Release mid-high-half: held high until the boundary, then low
        tick(1'b0, 4);
        for (int k = 1; k <= 3; k++) begin
            tick(1'b0, 0);
            chk("t3_out", audio_out, k < 3);
            chk("t3_sd",  audio_sd, SUSTAIN_ON ? 1 : (k < 3));
        end
        for (int k = 0; k < 50; k++) tick(1'b0, 0);
        chk("t3_end_sd",  audio_sd, 0);
        chk("t3_end_out", audio_out, 0);

        // Sub-minimum count is silence
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, (k < 5) ? 1 : 0);
            chk("t4_sd",  audio_sd, 0);
            chk("t4_out", audio_out, 0);
        end

        // Frequency change mid-half: current half completes at 4, then 6
        tick(1'b1, 0);
        run_start4();
        tick(1'b0, 4);
        for (int e = 16; e <= 31; e++) begin
            tick(1'b0, 6);
            chk("t2_out", audio_out, (e < 18) ? 1 : (((e - 18) / 6) % 2 == 1));
            chk("t2_sd",  audio_sd, 1);
        end

        // Minimum legal count and one long half
        for (int k = 0; k < 30; k++) tick(1'b0, 2);
        for (int k = 0; k < 700; k++) tick(1'b0, (k < 400) ? 300 : 0);

        // Randomized note sequences
        for (int s = 0; s < 220; s++) begin
            sel = $urandom_range(0, 11);
            if (sel <= 7)       f = sel;
            else if (sel <= 9)  f = $urandom_range(8, 40);
            else                f = 0;
            hold = $urandom_range(1, 50);
            for (int k = 0; k < hold; k++) begin
                tick(($urandom_range(0, 199) == 0), f);
            end
        end
        for (int k = 0; k < 200; k++) tick(1'b0, 0);
        chk("final_sd", audio_sd, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
